// File: rtl/rd_addr_cntl.sv
// ---------------------------------------------------------------------------
// rd_addr_cntl
//
// Read-side address and flag controller of an asynchronous FIFO. The
// Gray-coded write pointer is brought into the read clock domain through a
// two-flop synchronizer and converted to binary. From it, and from the local
// read pointer, the block derives the RAM read enable and address, a
// registered empty flag, a registered fill level and a read-data-valid
// strobe. The read pointer is exported in binary and Gray form so the write
// domain can build its own full flag.
//
// Pointer offset: the write pointer resets to 2^RD_ADDRW and the read
// pointer to 0. Occupancy is therefore (wbin - rptr - 2^RD_ADDRW) modulo
// 2^(RD_ADDRW+1), and the FIFO is empty when that value is zero.
//
// Ports
//   rclk             in   read-domain clock, rising edge
//   rst_n            in   synchronous active-low reset
//   wptr_gray_async  in   write pointer (Gray), asynchronous to rclk
//   rd_en            in   read request from the consumer
//   re               out  RAM read enable, rd_en & ~empty (combinational)
//   r_addr_ram       out  RAM read address, low bits of rptr
//   rptr             out  binary read pointer (registered)
//   rptr_gray        out  Gray read pointer (registered)
//   empty            out  registered empty flag
//   rd_level         out  registered occupancy, 0..2^RD_ADDRW
//   rd_valid         out  RAM data valid, one cycle after re
// ---------------------------------------------------------------------------
module rd_addr_cntl #(
  parameter int RD_ADDRW = 5
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic [RD_ADDRW:0]   wptr_gray_async,
  input  logic                rd_en,
  output logic                re,
  output logic [RD_ADDRW-1:0] r_addr_ram,
  output logic [RD_ADDRW:0]   rptr,
  output logic [RD_ADDRW:0]   rptr_gray,
  output logic                empty,
  output logic [RD_ADDRW:0]   rd_level,
  output logic                rd_valid
);

  localparam int PW = RD_ADDRW + 1;

  // Half the pointer range: the write-pointer reset offset.
  localparam logic [PW-1:0] HALF = PW'(1) << RD_ADDRW;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchronizer reset value: the write pointer's reset position in Gray.
  localparam logic [PW-1:0] WQ_RST = bin2gray(HALF);

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          valid_q;

  // Reads are only granted while data is known to be present.
  assign re = rd_en & ~empty_q;

  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    wbin        = gray2bin(wq2_q);
    rptr_d      = rptr_q + PW'(re);
    rptr_gray_d = bin2gray(rptr_d);
    // Flags use the post-read pointer so the last read empties the FIFO on
    // the same edge the pointer advances.
    level_d     = wbin - rptr_d - HALF;
    empty_d     = (level_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; the reset is synchronous, inside the clocked
  // block.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      wq1_q       <= WQ_RST;
      wq2_q       <= WQ_RST;
      rptr_q      <= '0;
      rptr_gray_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      // Two-flop synchronizer: the only logic that samples the async input.
      wq1_q       <= wptr_gray_async;
      wq2_q       <= wq1_q;
      rptr_q      <= rptr_d;
      rptr_gray_q <= rptr_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      // The RAM has one cycle of read latency.
      valid_q     <= re;
    end
  end

  assign r_addr_ram = rptr_q[RD_ADDRW-1:0];
  assign rptr       = rptr_q;
  assign rptr_gray  = rptr_gray_q;
  assign empty      = empty_q;
  assign rd_level   = level_q;
  assign rd_valid   = valid_q;

endmodule

// File: tb/tb_rd_addr_cntl.sv
// ---------------------------------------------------------------------------
// tb_rd_addr_cntl
//
// Directed steps followed by a randomized phase. The reference model counts
// words: the write pointer seen by the read side is the value presented two
// edges earlier, occupancy is written-minus-read less the reset offset, and
// a read happens only when the model believes data is present.
// ---------------------------------------------------------------------------
module tb_rd_addr_cntl;

  localparam int AW   = 5;
  localparam int PW   = AW + 1;
  localparam int MODP = 1 << PW;   // pointer modulus, 64
  localparam int DEP  = 1 << AW;   // FIFO depth, 32

  logic          rclk;
  logic          rst_n;
  logic [PW-1:0] wptr_gray_async;
  logic          rd_en;
  logic          re;
  logic [AW-1:0] r_addr_ram;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rptr_gray;
  logic          empty;
  logic [PW-1:0] rd_level;
  logic          rd_valid;

  rd_addr_cntl #(.RD_ADDRW(AW)) dut (
    .rclk            (rclk),
    .rst_n           (rst_n),
    .wptr_gray_async (wptr_gray_async),
    .rd_en           (rd_en),
    .re              (re),
    .r_addr_ram      (r_addr_ram),
    .rptr            (rptr),
    .rptr_gray       (rptr_gray),
    .empty           (empty),
    .rd_level        (rd_level),
    .rd_valid        (rd_valid)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit known  = 1'b0;   // set once a reset edge has been seen
  int m_rptr = 0;      // words read, modulo 64
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_valid = 1'b0;
  int w_hist[$];       // write pointer values captured at the last two edges
  logic [PW-1:0] prev_gray;
  int prev_rptr;
  bit saw_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // step the model at the edge and check registered outputs just after it.
  task automatic cycle(input bit rst, input bit rd, input int wb);
    bit fire;
    int vis;
    rst_n           = ~rst;
    rd_en           = rd;
    wptr_gray_async = to_gray(wb);
    @(negedge rclk);
    fire = rd && !m_empty;
    if (known) begin
      check("re", re, fire);
      if (fire) check("r_addr_ram", r_addr_ram, m_rptr % DEP);
    end
    @(posedge rclk);
    prev_gray = rptr_gray;
    prev_rptr = m_rptr;
    if (rst) begin
      known   = 1'b1;
      m_rptr  = 0;
      m_level = 0;
      m_empty = 1'b1;
      m_valid = 1'b0;
      w_hist  = '{DEP, DEP};
    end else begin
      vis = w_hist.pop_front();
      w_hist.push_back(wb % MODP);
      if (fire) m_rptr = (m_rptr + 1) % MODP;
      m_level = (vis - m_rptr - DEP + 2 * MODP) % MODP;
      m_empty = (m_level == 0);
      m_valid = fire;
      if (prev_rptr == MODP - 1 && m_rptr == 0) saw_wrap = 1'b1;
    end
    #1;
    if (known) begin
      check("rptr", rptr, m_rptr);
      check("rptr_gray", rptr_gray, to_gray(m_rptr));
      check("empty", empty, m_empty);
      check("rd_level", rd_level, m_level);
      check("rd_valid", rd_valid, m_valid);
      if (!rst) check("gray_one_bit", $countones(rptr_gray ^ prev_gray) <= 1, 1);
    end
  endtask

  initial begin
    int w;
    int occ;
    rst_n           = 1'b0;
    rd_en           = 1'b0;
    wptr_gray_async = to_gray(DEP);
    w_hist          = '{DEP, DEP};
    prev_gray       = '0;
    prev_rptr       = 0;

    // Reset held for two edges with a read request pending.
    cycle(1'b1, 1'b1, DEP);
    cycle(1'b1, 1'b1, DEP);
    check("rst_re", re, 0);
    check("rst_empty", empty, 1);

    // One write becomes visible exactly at the third edge.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, DEP + 1);
      check("wlat_empty", empty, (i < 2) ? 1 : 0);
    end
    check("wlat_level", rd_level, 1);

    // Single read of the only word.
    cycle(1'b0, 1'b1, DEP + 1);
    check("single_rptr_gray", rptr_gray, 6'b000001);
    check("single_valid", rd_valid, 1);
    cycle(1'b0, 1'b0, DEP + 1);
    check("single_valid_drop", rd_valid, 0);

    // Underflow: reads requested while empty do nothing.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, DEP + 1);
    check("underflow_rptr", rptr, 1);

    // Fill to full, then drain with continuous reads.
    w = m_rptr;  // write pointer 2^AW ahead of the offset: full
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, w);
    check("full_level", rd_level, DEP);
    check("full_empty", empty, 0);
    for (int i = 0; i < DEP + 2; i++) cycle(1'b0, 1'b1, w);
    check("drain_rptr", rptr, 33);
    check("drain_empty", empty, 1);

    // Streaming writes and reads across the pointer wrap, then a reset.
    for (int i = 0; i < 70; i++) begin
      if (i == 60) begin
        w = DEP;
        cycle(1'b1, 1'b1, w);
        check("midrst_rptr", rptr, 0);
        check("midrst_valid", rd_valid, 0);
      end else begin
        w = (w + 1) % MODP;
        cycle(1'b0, 1'b1, w);
      end
    end
    check("saw_wrap", saw_wrap, 1);

    // Randomized traffic with an occasional reset; the writer never
    // overfills relative to the read pointer.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        w = DEP;
        cycle(1'b1, 1'($urandom_range(1)), w);
      end else begin
        occ = (w - m_rptr - DEP + 2 * MODP) % MODP;
        if (occ < DEP && $urandom_range(99) < 55) w = (w + 1) % MODP;
        cycle(1'b0, 1'($urandom_range(99) < 50), w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
